// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared constants for the memory-mapped UART transmitter
//
// Purpose : TX state encoding, status word bit positions, register word offsets
//           and a count-saturation helper shared by the uart_tx_mmio files.
// Ports   : none (package).
package uart_tx_mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Status word bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // Register word offsets from BASE_WADDR
    localparam logic [29:0] REG_OFF_DATA   = 30'd0;
    localparam logic [29:0] REG_OFF_STATUS = 30'd1;

    // FIFO count as reported in the 4-bit status field
    function automatic logic [3:0] sat_count4(input int unsigned c);
        logic [3:0] r;
        r = (c > 32'd15) ? 4'hF : c[3:0];
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo_sync.sv
// rtl/uart_tx_mmio_fifo_sync.sv - synchronous FIFO with push/pop/full/empty/count
//
// Purpose : Generic single-clock FIFO, first-word fall-through read data.
// Ports   : clk, rst (async active-low)
//           i_push, i_wdata  - write side; dropped when full unless popping too
//           i_pop, o_rdata   - read side; o_rdata is the head entry
//           o_full, o_empty, o_count - occupancy
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push while full is still taken.
    // When full the write slot is the head slot; the head is read before it is overwritten.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter on the core store bus
//
// Purpose : Byte stores to BASE_WADDR are queued and sent as 8N1 frames on tx.
//           BASE_WADDR+1 is a status word (busy/full/empty/ovf/count); storing
//           bit3=1 there clears the sticky overflow flag.
// Ports   : clk, rst (async active-low)
//           addr[29:0], data_in[31:0], wes[3:0] - core store/read bus
//           rdata[31:0], hit                     - registered one-cycle read return
//           tx                                   - serial line, idle high
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR = 30'h0000_0400,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data_in,
    input  logic [3:0]  wes,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx
);

    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);
    localparam logic [29:0]       DATA_WADDR  = BASE_WADDR + REG_OFF_DATA;
    localparam logic [29:0]       STAT_WADDR  = BASE_WADDR + REG_OFF_STATUS;

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_ovf;
    logic [31:0]       r_rdata;
    logic              r_hit;

    logic              w_sel_data;
    logic              w_sel_stat;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_clr;
    logic              w_baud_last;
    logic [7:0]        w_fifo_data;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_status;
    logic              w_unused_bus;

    assign w_sel_data  = (addr == DATA_WADDR);
    assign w_sel_stat  = (addr == STAT_WADDR);
    assign w_push      = w_sel_data && wes[0];
    assign w_ovf_clr   = w_sel_stat && wes[0] && data_in[3];
    assign w_baud_last = (r_baud == BAUD_LAST);

    // The FSM takes a byte from IDLE, or on the final stop-bit cycle so frames abut.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last));

    assign w_unused_bus = ^{data_in[31:8], wes[3:1]};

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (data_in[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                                = '0;
        w_status[STAT_BUSY]                     = (r_state != ST_IDLE);
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_OVF]                      = r_ovf;
        w_status[STAT_CNT_LSB+3:STAT_CNT_LSB]   = sat_count4(32'(w_count));
    end

    // Sticky overflow: a dropped push wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_rdata <= w_sel_stat ? w_status : 32'd0;
            r_hit   <= w_sel_data || w_sel_stat;
        end
    end

    // TX FSM: the shift register moves right once per data bit so tx always takes bit 1 next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_fifo_data;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_fifo_data;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign hit   = r_hit;
    assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio
module tb_uart_tx_mmio;

    localparam int          CD    = 4;
    localparam int          DEPTH = 8;
    localparam logic [29:0] BASE  = 30'h0000_0400;
    localparam logic [29:0] STAT  = 30'h0000_0401;
    localparam int          FLEN  = 10 * CD;

    logic        clk;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data_in;
    logic [3:0]  wes;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;

    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [31:0] exp_q[$];
    int          starts[$];
    logic        in_frame;

    uart_tx_mmio #(
        .BASE_WADDR (BASE),
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wes     (wes),
        .rdata   (rdata),
        .hit     (hit),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr    = a;
        data_in = d;
        wes     = w;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        addr    = 30'd0;
        data_in = 32'd0;
        wes     = 4'd0;
    endtask

    task automatic read_status(output logic [31:0] d, output logic h);
        @(negedge clk);
        addr = STAT;
        wes  = 4'd0;
        @(negedge clk);
        d    = rdata;
        h    = hit;
        addr = 30'd0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Frame monitor: samples tx on every negedge, decodes 8N1 and pops the scoreboard.
    initial begin
        logic        smp[FLEN];
        logic        aborted;
        logic        shape_ok;
        logic [31:0] got;
        logic [31:0] exp;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && tx == 1'b0) begin
                in_frame = 1'b1;
                aborted  = 1'b0;
                starts.push_back(cyc);
                for (int i = 0; i < FLEN; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = tx;
                end
                if (!aborted) begin
                    shape_ok = 1'b1;
                    for (int s = 0; s < 10; s++)
                        for (int k = 1; k < CD; k++)
                            if (smp[s*CD+k] !== smp[s*CD]) shape_ok = 1'b0;
                    if (smp[0] !== 1'b0 || smp[9*CD] !== 1'b1) shape_ok = 1'b0;
                    got = '0;
                    for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*CD];
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h100;
                    check("frame_shape", {31'd0, shape_ok}, 32'd1);
                    check("frame_byte", got, exp);
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] st;
        logic        h;
        int          store_cyc;
        int          lows;
        int          n;

        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        rst     = 1'b0;
        addr    = 30'd0;
        data_in = 32'd0;
        wes     = 4'd0;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_hit", {31'd0, hit}, 32'd0);
        #2 rst = 1'b1;

        // Status read latency and unrelated address
        read_status(st, h);
        check("stat_hit", {31'd0, h}, 32'd1);
        check("stat_idle", st, 32'h0000_0004);
        @(negedge clk);
        addr = 30'h123;
        @(negedge clk);
        check("other_hit", {31'd0, hit}, 32'd0);
        check("other_rdata", rdata, 32'd0);
        addr = 30'd0;

        // Byte-lane gating: wes[0]=0 never pushes
        bus_write(BASE, 32'h0000_0077, 4'b1110);
        bus_idle();
        read_status(st, h);
        check("lane_status", st, 32'h0000_0004);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("lane_tx_idle", 32'(lows), 32'd0);

        // Single byte
        starts.delete();
        bus_write(BASE, 32'h0000_0055, 4'b0001);
        exp_q.push_back(32'h55);
        bus_idle();
        store_cyc = cyc;
        wait_drain(FLEN + 20);
        check("single_start", 32'(starts.size() > 0 ? starts[0] : -1), 32'(store_cyc + 1));
        read_status(st, h);
        check("single_notbusy", st, 32'h0000_0004);

        // Back-to-back
        starts.delete();
        bus_write(BASE, 32'h01, 4'b0001); exp_q.push_back(32'h01);
        bus_write(BASE, 32'h80, 4'b0001); exp_q.push_back(32'h80);
        bus_write(BASE, 32'hFF, 4'b0001); exp_q.push_back(32'hFF);
        bus_idle();
        wait_drain(3 * FLEN + 20);
        check("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FLEN));
            check("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FLEN));
        end
        read_status(st, h);
        check("b2b_empty", st, 32'h0000_0004);

        // Overflow: byte 0 popped, bytes 1..8 queued, byte 9 dropped
        for (int i = 0; i < 10; i++) begin
            bus_write(BASE, 32'(8'hA0 + i), 4'b0001);
            if (i < 9) exp_q.push_back(32'(8'hA0 + i));
        end
        read_status(st, h);
        check("ovf_status", st, 32'h0000_008B);
        bus_write(STAT, 32'h0000_0008, 4'b0001);
        bus_idle();
        read_status(st, h);
        check("ovf_cleared", st, 32'h0000_0083);
        wait_drain(9 * FLEN + 40);
        read_status(st, h);
        check("ovf_drained", st, 32'h0000_0004);

        // Reset during data bit 3
        starts.delete();
        bus_write(BASE, 32'hC3, 4'b0001); exp_q.push_back(32'hC3);
        bus_write(BASE, 32'h3C, 4'b0001); exp_q.push_back(32'h3C);
        bus_idle();
        n = 0;
        while (starts.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_frame_started", 32'(starts.size()), 32'd1);
        n = 0;
        while (starts.size() > 0 && cyc != starts[0] + 17 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_pre_bit3", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1 check("rst_async_tx", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        exp_q.delete();
        #2 rst = 1'b1;
        read_status(st, h);
        check("rst_status", st, 32'h0000_0004);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("rst_no_residual", 32'(lows), 32'd0);
        check("rst_frames", 32'(starts.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
